// File: rtl/ula_operand_issue.sv
// Purpose: decode nRisc instruction bytes, read the register file and issue dReg/extd/ULASrc to the ULA-source MUX.
// Latency: bundle valid the cycle after the final byte is accepted (1 byte for R/short, 2 bytes for long immediate).
// Backpressure: one registered output entry; in_ready = !out_valid || out_ready (forced low by flush).
// Optional: define OPERAND_WB_FWD_EN to bypass same-cycle write-back data into the register reads.
module ula_operand_issue #(
   parameter int DATA_W = 8,
   parameter int NREG   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_byte,
   input  logic              wb_en,
   input  logic [1:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_opcode,
   output logic [1:0]        out_rd,
   output logic [DATA_W-1:0] dReg,
   output logic [DATA_W-1:0] extd,
   output logic              ULASrc
);

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_IMM = 1'b1
   } state_t;

   typedef struct packed {
      logic [3:0]        opcode;
      logic [1:0]        rd;
      logic [DATA_W-1:0] dreg;
      logic [DATA_W-1:0] extd;
      logic              ulasrc;
   } bundle_t;

   state_t            state;
   logic [3:0]        pend_op;
   logic [1:0]        pend_ra;
   bundle_t           out_q;
   logic              out_vld_q;
   logic [DATA_W-1:0] rf [NREG];

   logic              in_acc;
   logic              is_long;
   logic              load;
   logic [3:0]        byte_op;
   logic [1:0]        rd_a_addr;
   logic [1:0]        rd_b_addr;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] imm2_sext;
   bundle_t           nxt;

   assign in_ready  = !flush && (!out_vld_q || out_ready);
   assign in_acc    = in_valid && in_ready;
   assign byte_op   = in_byte[7:4];
   assign is_long   = (byte_op[3:2] == 2'b11);
   // the byte completing an instruction: any byte in WAIT_IMM, or a non-long opcode in IDLE
   assign load      = in_acc && ((state == WAIT_IMM) || !is_long);

   // in WAIT_IMM the current byte is imm8, so ra comes from the latched first byte
   assign rd_a_addr = (state == WAIT_IMM) ? pend_ra : in_byte[3:2];
   assign rd_b_addr = in_byte[1:0];

`ifdef OPERAND_WB_FWD_EN
   assign rd_a = (wb_en && (wb_addr == rd_a_addr)) ? wb_data : rf[rd_a_addr];
   assign rd_b = (wb_en && (wb_addr == rd_b_addr)) ? wb_data : rf[rd_b_addr];
`else
   assign rd_a = rf[rd_a_addr];
   assign rd_b = rf[rd_b_addr];
`endif

   assign imm2_sext = {{(DATA_W-2){in_byte[1]}}, in_byte[1:0]};

   // Build the bundle that would be loaded if the current byte completes an instruction
   always_comb begin
      imm_ext      = '0;
      imm_ext[7:0] = in_byte;
      nxt          = '0;
      if (state == WAIT_IMM) begin
         nxt.opcode = pend_op;
         nxt.rd     = pend_ra;
         nxt.dreg   = rd_a;
         nxt.extd   = imm_ext;
         nxt.ulasrc = 1'b1;
      end else if (!byte_op[3]) begin
         nxt.opcode = byte_op;
         nxt.rd     = in_byte[3:2];
         nxt.dreg   = rd_a;
         nxt.extd   = rd_b;
         nxt.ulasrc = 1'b0;
      end else begin
         nxt.opcode = byte_op;
         nxt.rd     = in_byte[3:2];
         nxt.dreg   = rd_a;
         nxt.extd   = imm2_sext;
         nxt.ulasrc = 1'b1;
      end
   end

   // Issue FSM and registered output entry; flush overrides everything except write-back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pend_op   <= '0;
         pend_ra   <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         out_vld_q <= 1'b0;
      end else begin
         if (load) begin
            out_q     <= nxt;
            out_vld_q <= 1'b1;
         end else if (out_ready) begin
            out_vld_q <= 1'b0;
         end
         if (in_acc) begin
            if (state == IDLE) begin
               if (is_long) begin
                  state   <= WAIT_IMM;
                  pend_op <= byte_op;
                  pend_ra <= in_byte[3:2];
               end
            end else begin
               state <= IDLE;
            end
         end
      end
   end

   // Register file write-back; commits even while flushing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            rf[i] <= '0;
         end
      end else if (wb_en) begin
         rf[wb_addr] <= wb_data;
      end
   end

   assign out_valid  = out_vld_q;
   assign out_opcode = out_q.opcode;
   assign out_rd     = out_q.rd;
   assign dReg       = out_q.dreg;
   assign extd       = out_q.extd;
   assign ULASrc     = out_q.ulasrc;

endmodule

// File: tb/tb_ula_operand_issue.sv
// Bench for ula_operand_issue: a reference model predicts acceptance and issued bundles into a queue,
// and a negedge monitor compares the DUT output against the queue head while the bundle is valid.
// Directed cases first, then randomized bytes, write-backs, flushes and consumer stalls.
module tb_ula_operand_issue;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_byte;
   logic       wb_en;
   logic [1:0] wb_addr;
   logic [7:0] wb_data;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_opcode;
   logic [1:0] out_rd;
   logic [7:0] dReg;
   logic [7:0] extd;
   logic       ULASrc;

   ula_operand_issue #(.DATA_W(8), .NREG(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_rd(out_rd),
      .dReg(dReg), .extd(extd), .ULASrc(ULASrc)
   );

   typedef struct packed {
      logic [3:0] op;
      logic [1:0] rd;
      logic [7:0] d;
      logic [7:0] e;
      logic       src;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled
   exp_t q[$];

   // reference model state
   logic [7:0] m_rf [4];
   bit         m_vld = 0;
   bit         m_wait = 0;
   bit         m_acc = 0;
   int         m_pop = 0;
   int         m_pra = 0;
   bit         m_fin;
   exp_t       m_e;
   int         m_s;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [7:0] rd(input int a);
`ifdef OPERAND_WB_FWD_EN
      if (wb_en && int'(wb_addr) == a) return wb_data;
`endif
      return m_rf[a];
   endfunction

   // Model: acceptance, instruction assembly and register file, evaluated on each clock edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_vld  = 0;
         m_wait = 0;
         m_acc  = 0;
         q.delete();
         for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
      end else begin
         m_acc = in_valid && !flush && (!m_vld || out_ready);
         m_fin = 0;
         if (flush) begin
            m_vld  = 0;
            m_wait = 0;
            q.delete();
         end else begin
            if (m_acc) begin
               if (m_wait) begin
                  m_e    = '{op: 4'(m_pop), rd: 2'(m_pra), d: rd(m_pra), e: in_byte, src: 1'b1};
                  m_wait = 0;
                  m_fin  = 1;
               end else if (in_byte[7:4] >= 4'd12) begin
                  m_wait = 1;
                  m_pop  = int'(in_byte[7:4]);
                  m_pra  = int'(in_byte[3:2]);
               end else if (in_byte[7:4] < 4'd8) begin
                  m_e   = '{op: in_byte[7:4], rd: in_byte[3:2], d: rd(int'(in_byte[3:2])),
                            e: rd(int'(in_byte[1:0])), src: 1'b0};
                  m_fin = 1;
               end else begin
                  m_s = int'(in_byte[1:0]);
                  if (m_s > 1) m_s = m_s - 4;
                  m_e   = '{op: in_byte[7:4], rd: in_byte[3:2], d: rd(int'(in_byte[3:2])),
                            e: 8'(m_s), src: 1'b1};
                  m_fin = 1;
               end
            end
            if (m_fin) begin
               q.push_back(m_e);
               m_vld = 1;
            end else if (out_ready) begin
               m_vld = 0;
            end
         end
         if (wb_en) m_rf[wb_addr] = wb_data;
      end
   end

   // Monitor: compare handshake and bundle against the model away from the active edge
   always @(negedge clk) begin
      chk("out_valid", 32'(out_valid), 32'(m_vld));
      chk("in_ready", 32'(in_ready), 32'(!flush && (!m_vld || out_ready)));
      if (out_valid && m_vld) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=bundle required=none at %0t", $time);
         end else begin
            chk("out_opcode", 32'(out_opcode), 32'(q[0].op));
            chk("out_rd", 32'(out_rd), 32'(q[0].rd));
            chk("dReg", 32'(dReg), 32'(q[0].d));
            chk("extd", 32'(extd), 32'(q[0].e));
            chk("ULASrc", 32'(ULASrc), 32'(q[0].src));
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   // Consumer
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = ($urandom % 4) != 0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bit done;
      done     = 0;
      in_valid = 1'b1;
      in_byte  = b;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         wb_en = 1'b0;
         if (m_acc) done = 1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=none required=accept byte=%0h", b);
      end
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
      wb_en   = 1'b1;
      wb_addr = a;
      wb_data = d;
      tick();
      wb_en   = 1'b0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_opcode", 32'(out_opcode), 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      chk("rst_dReg", 32'(dReg), 32'd0);
      chk("rst_extd", 32'(extd), 32'd0);
      chk("rst_ULASrc", 32'(ULASrc), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      wb_en    = 1'b0;
      wb_addr  = 2'd0;
      wb_data  = 8'h00;
      flush    = 1'b0;
      repeat (2) tick();
      chk_reset_outputs();
      rst_n = 1'b1;
      tick();

      // R-type, short immediates, long immediate with an idle gap
      wb_write(2'd1, 8'h11);
      wb_write(2'd2, 8'h2D);
      send(8'h06);
      send(8'h87);
      send(8'h85);
      send(8'hC8);
      repeat (3) tick();
      send(8'h2D);
      tick();

      // consumer stall holds the bundle, then back-to-back issue on release
      rdy_mode = 2;
      repeat (2) tick();
      send(8'h06);
      in_valid = 1'b1;
      in_byte  = 8'h09;
      repeat (4) tick();
      rdy_mode = 1;
      send(8'h09);
      repeat (2) tick();

      // write-back colliding with the load-cycle read of R1
      wb_en   = 1'b1;
      wb_addr = 2'd1;
      wb_data = 8'hA5;
      send(8'h06);
      tick();

      // flush in WAIT_IMM with a simultaneous write-back, then a fresh instruction
      send(8'hC4);
      flush   = 1'b1;
      wb_en   = 1'b1;
      wb_addr = 2'd3;
      wb_data = 8'h5A;
      in_valid = 1'b1;
      in_byte  = 8'h3C;
      tick();
      flush    = 1'b0;
      wb_en    = 1'b0;
      in_valid = 1'b0;
      send(8'h0F);
      tick();

      // reset in the middle of a long immediate
      send(8'hCC);
      rst_n = 1'b0;
      #2;
      chk_reset_outputs();
      tick();
      rst_n = 1'b1;
      send(8'h06);
      send(8'h8B);
      repeat (3) tick();

      // randomized traffic
      rdy_mode = 0;
      repeat (500) begin
         in_valid = ($urandom % 3) != 0;
         in_byte  = 8'($urandom);
         wb_en    = ($urandom % 4) == 0;
         wb_addr  = 2'($urandom);
         wb_data  = 8'($urandom);
         flush    = ($urandom % 25) == 0;
         tick();
      end
      in_valid = 1'b0;
      wb_en    = 1'b0;
      flush    = 1'b0;
      rdy_mode = 1;
      repeat (6) tick();
      chk("drain_queue", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ula_operand_issue.md
Name: ula_operand_issue

Overview:
- Producer end of the ULA operand interface: decodes 8-bit nRisc instruction bytes, reads the 4-entry register file, builds the immediate, and presents dReg / extd / ULASrc to the ULA-source MUX stage.
- Registered one-entry output with a valid/ready handshake, so the execute stage can stall issue.
- Write-back port updates the register file.
- Sits between instruction fetch and the ULA-source MUX.

Parameters:
- DATA_W, 8, datapath and register width; instruction bytes are always 8 bits.
- NREG, 4, register-file depth; fixed by the 2-bit register fields.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction/immediate byte valid
- in_ready  output  1  unit accepts in_byte this cycle
- in_byte  input  8  instruction byte or long-immediate byte
- wb_en  input  1  register write enable
- wb_addr  input  2  register write address
- wb_data  input  DATA_W  register write data
- flush  input  1  synchronous discard of partial instruction and output entry
- out_valid  output  1  operand bundle valid
- out_ready  input  1  consumer takes bundle
- out_opcode  output  4  opcode of issued instruction
- out_rd  output  2  destination register (ra field)
- dReg  output  DATA_W  R[ra]
- extd  output  DATA_W  R[rb] or extended immediate
- ULASrc  output  1  0 = extd holds a register value, 1 = extd holds an immediate

Behaviour:
- Instruction format: opcode = in_byte[7:4], ra = in_byte[3:2], rb/imm2 = in_byte[1:0].
- Instruction classes:
  - opcode[3]=0: R-type. dReg=R[ra], extd=R[rb], ULASrc=0.
  - opcode[3:2]=10: short immediate. dReg=R[ra], extd=sign-extend(imm2) (2'b11 -> 8'hFF), ULASrc=1.
  - opcode[3:2]=11: long immediate. The next accepted byte is imm8; dReg=R[ra], extd=imm8, ULASrc=1.
- FSM states:
  - IDLE: in accept, R-type or short -> load output register, stay IDLE; long -> latch opcode/ra, go WAIT_IMM.
  - WAIT_IMM: in accept -> load output with imm8, go IDLE.
- Acceptance and handshake:
  - in_ready = !out_valid || out_ready, in both states. A transfer occurs when in_valid && in_ready.
  - Register file is read in the cycle the final byte is accepted. For long form, ra is latched from the first byte and R[ra] is read at imm-byte acceptance.
  - Latency: bundle visible with out_valid=1 the cycle after the final byte is accepted.
  - Output holds stable while out_valid && !out_ready. Simultaneous out_ready and a new final byte gives a back-to-back load: out_valid stays 1 and the fields update.
  - out_valid clears on out_ready when no new load occurs.
- Write-back: R[wb_addr] <= wb_data on the edge when wb_en=1. No hardwired-zero register.
- Flush: synchronous and highest priority. Clears out_valid, returns to IDLE, drops any byte offered that cycle; in_ready is forced 0 during flush. A write-back in the same cycle still commits.
- Reset (asynchronous, any state, including WAIT_IMM): state=IDLE, out_valid=0, out_opcode=0, out_rd=0, dReg=0, extd=0, ULASrc=0, all registers = 0.

Optional Feature:
- Macro OPERAND_WB_FWD_EN.
- Defined: if wb_en=1 and wb_addr matches a register read in the load cycle, the read returns wb_data (bypass). This applies to ra and rb independently.
- Undefined: the load cycle returns the pre-write register value; the write is visible from the next cycle.

Test Plan:
- Reset, write R1=8'h11 and R2=8'h2D, feed 8'h06 (op0, ra=1, rb=2) -> next cycle out_valid=1, dReg=8'h11, extd=8'h2D, ULASrc=0, out_rd=1.
- Short immediate 8'h87 (op8, ra=1, imm2=11) -> dReg=8'h11, extd=8'hFF, ULASrc=1. Then 8'h85 -> extd=8'h01.
- Long immediate 8'hC8 followed by 8'h2D with a 3-cycle in_valid gap between bytes -> out_valid stays 0 in WAIT_IMM; one cycle after imm accept: dReg=R[2], extd=8'h2D, ULASrc=1.
- Hold out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, outputs stable. Then out_ready=1 with a new byte offered -> back-to-back issue with no bubble.
- wb_en=1, wb_addr=1, wb_data=8'hA5 in the same cycle as accepting 8'h06 -> with OPERAND_WB_FWD_EN dReg=8'hA5, without it dReg=8'h11.
- Flush asserted in WAIT_IMM, and separately rst_n pulsed low mid-long-instruction -> state IDLE, out_valid=0, the next byte is decoded as a fresh instruction. After reset, all register reads return 0.
